// File: rtl/xif_credit_dispatcher_if.sv
// Core-side X-interface bundle for xif_credit_dispatcher: the issue request,
// the immediate accept/writeback response and the registered result stream.
interface xif_credit_dispatcher_if #(
  parameter int unsigned ID_W = 4,
  parameter int unsigned XLEN = 32
);
  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_instr;
  logic [ID_W-1:0] issue_id;
  logic            issue_accept;
  logic            issue_writeback;
  logic            result_valid;
  logic            result_ready;
  logic [ID_W-1:0] result_id;
  logic [XLEN-1:0] result_data;
  logic [4:0]      result_rd;
  logic            result_we;

  modport master (
    output issue_valid, issue_instr, issue_id, result_ready,
    input  issue_ready, issue_accept, issue_writeback,
    input  result_valid, result_id, result_data, result_rd, result_we
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, result_ready,
    output issue_ready, issue_accept, issue_writeback,
    output result_valid, result_id, result_data, result_rd, result_we
  );
endinterface

// File: rtl/xif_credit_dispatcher.sv
// X-interface dispatcher: routes core issues to one of N_COPROC coprocessors by
// {opcode, func3} signature, throttles each coprocessor by its outstanding
// writeback credits, and merges coprocessor results round-robin into a single
// registered result stage towards the core.
// Optional build macro: XIF_DISP_PERF_EN enables the issue/stall performance
// counters; without it both counter outputs are constant zero.
module xif_credit_dispatcher #(
  parameter int unsigned N_COPROC    = 4,
  parameter int unsigned N_RULES     = 3,
  parameter int unsigned N_SIGN      = 4,
  parameter int unsigned DEFAULT_IDX = 0,
  parameter int unsigned MAX_OUTST   = 4,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned XLEN        = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_RULES*N_SIGN*10-1:0] rules_sign_i,
  input  logic [N_RULES*N_SIGN-1:0]    rules_en_i,
  xif_credit_dispatcher_if.slave       xif,
  output logic [N_COPROC-1:0]          cp_issue_valid_o,
  input  logic [N_COPROC-1:0]          cp_issue_ready_i,
  output logic [31:0]                  cp_issue_instr_o,
  output logic [ID_W-1:0]              cp_issue_id_o,
  input  logic [N_COPROC-1:0]          cp_accept_i,
  input  logic [N_COPROC-1:0]          cp_writeback_i,
  input  logic [N_COPROC-1:0]          cp_result_valid_i,
  output logic [N_COPROC-1:0]          cp_result_ready_o,
  input  logic [N_COPROC*ID_W-1:0]     cp_result_id_i,
  input  logic [N_COPROC*XLEN-1:0]     cp_result_data_i,
  input  logic [N_COPROC*5-1:0]        cp_result_rd_i,
  input  logic [N_COPROC-1:0]          cp_result_we_i,
  output logic                         err_o,
  output logic [31:0]                  perf_issue_cnt_o,
  output logic [31:0]                  perf_stall_cnt_o
);

  localparam int unsigned SEL_W  = (N_COPROC > 1) ? $clog2(N_COPROC) : 1;
  localparam int unsigned SCAN_W = SEL_W + 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  // ---------------- issue side ----------------
  logic [9:0]          sign_s;
  logic [N_RULES-1:0]  rule_hit_s;
  logic [SEL_W-1:0]    sel_s;
  logic                stall_s;
  logic                issue_ready_s;
  logic                issue_hs_s;
  logic                credit_take_s;

  // ---------------- result side ----------------
  logic                free_s;
  logic                grant_valid_s;
  logic [SEL_W-1:0]    grant_idx_s;
  logic [SCAN_W-1:0]   scan_s;
  logic [SEL_W-1:0]    rr_next_s;
  logic [ID_W-1:0]     gnt_id_s;
  logic [XLEN-1:0]     gnt_data_s;
  logic [4:0]          gnt_rd_s;
  logic                gnt_we_s;

  // ---------------- state ----------------
  logic [CNT_W-1:0]    cnt_r [N_COPROC];
  logic [N_COPROC-1:0] cnt_inc_s;
  logic [N_COPROC-1:0] cnt_dec_s;
  logic [SEL_W-1:0]    rr_ptr_r;
  logic                result_valid_r;
  logic [ID_W-1:0]     result_id_r;
  logic [XLEN-1:0]     result_data_r;
  logic [4:0]          result_rd_r;
  logic                result_we_r;
  logic                err_r;

  assign sign_s = {xif.issue_instr[6:0], xif.issue_instr[14:12]};

  // Flag every rule that has at least one enabled signature equal to sign_s
  always_comb begin
    rule_hit_s = '0;
    for (int i = 0; i < int'(N_RULES); i++) begin
      for (int j = 0; j < int'(N_SIGN); j++) begin
        if (rules_en_i[i*N_SIGN+j] && (rules_sign_i[(i*N_SIGN+j)*10 +: 10] == sign_s)) begin
          rule_hit_s[i] = 1'b1;
        end else begin
          rule_hit_s[i] = rule_hit_s[i];
        end
      end
    end
  end

  // Lowest matching rule wins; scanning downwards lets the lowest overwrite last
  always_comb begin
    sel_s = SEL_W'(DEFAULT_IDX);
    for (int i = int'(N_RULES) - 1; i >= 0; i--) begin
      if (rule_hit_s[i]) begin
        sel_s = SEL_W'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  assign stall_s       = (cnt_r[sel_s] == MAX_CNT);
  assign issue_ready_s = cp_issue_ready_i[sel_s] & ~stall_s;
  assign issue_hs_s    = xif.issue_valid & issue_ready_s;
  assign credit_take_s = issue_hs_s & cp_accept_i[sel_s] & cp_writeback_i[sel_s];

  assign xif.issue_ready     = issue_ready_s;
  assign xif.issue_accept    = cp_accept_i[sel_s] & ~stall_s;
  assign xif.issue_writeback = cp_writeback_i[sel_s] & ~stall_s;
  assign cp_issue_instr_o    = xif.issue_instr;
  assign cp_issue_id_o       = xif.issue_id;

  // Forward issue valid only to the selected coprocessor, gated by its credits
  always_comb begin
    cp_issue_valid_o        = '0;
    cp_issue_valid_o[sel_s] = xif.issue_valid & ~stall_s;
  end

  assign free_s = ~result_valid_r | xif.result_ready;

  // Round-robin search: first valid coprocessor at or after rr_ptr, wrapping
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    scan_s        = '0;
    for (int k = 0; k < int'(N_COPROC); k++) begin
      scan_s = {1'b0, rr_ptr_r} + SCAN_W'(k);
      if (scan_s >= SCAN_W'(N_COPROC)) begin
        scan_s = scan_s - SCAN_W'(N_COPROC);
      end else begin
        scan_s = scan_s;
      end
      if (free_s && !grant_valid_s && cp_result_valid_i[scan_s[SEL_W-1:0]]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = scan_s[SEL_W-1:0];
      end else begin
        grant_valid_s = grant_valid_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Ready goes back only to the granted coprocessor, only in the grant cycle
  always_comb begin
    cp_result_ready_o = '0;
    if (grant_valid_s) begin
      cp_result_ready_o[grant_idx_s] = 1'b1;
    end else begin
      cp_result_ready_o = '0;
    end
  end

  // Pointer advances to the index just past the winner
  always_comb begin
    if (grant_idx_s == SEL_W'(N_COPROC - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_idx_s + SEL_W'(1);
    end
  end

  assign gnt_id_s   = cp_result_id_i[grant_idx_s*ID_W +: ID_W];
  assign gnt_data_s = cp_result_data_i[grant_idx_s*XLEN +: XLEN];
  assign gnt_rd_s   = cp_result_rd_i[grant_idx_s*5 +: 5];
  assign gnt_we_s   = cp_result_we_i[grant_idx_s];

  // Per-coprocessor credit take/return requests for this cycle
  always_comb begin
    cnt_inc_s = '0;
    cnt_dec_s = '0;
    cnt_inc_s[sel_s] = credit_take_s;
    if (grant_valid_s) begin
      cnt_dec_s[grant_idx_s] = 1'b1;
    end else begin
      cnt_dec_s = '0;
    end
  end

  // Outstanding-credit counters; simultaneous take and return cancel out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < int'(N_COPROC); c++) begin
        cnt_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < int'(N_COPROC); c++) begin
        if (cnt_inc_s[c] && !cnt_dec_s[c] && (cnt_r[c] != MAX_CNT)) begin
          cnt_r[c] <= cnt_r[c] + CNT_W'(1);
        end else if (cnt_dec_s[c] && !cnt_inc_s[c] && (cnt_r[c] != '0)) begin
          cnt_r[c] <= cnt_r[c] - CNT_W'(1);
        end else begin
          cnt_r[c] <= cnt_r[c];
        end
      end
    end
  end

  // Registered result stage: capture on grant, drop on consume, else hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_r <= 1'b0;
      result_id_r    <= '0;
      result_data_r  <= '0;
      result_rd_r    <= 5'd0;
      result_we_r    <= 1'b0;
      rr_ptr_r       <= '0;
    end else if (grant_valid_s) begin
      result_valid_r <= 1'b1;
      result_id_r    <= gnt_id_s;
      result_data_r  <= gnt_data_s;
      result_rd_r    <= gnt_rd_s;
      result_we_r    <= gnt_we_s;
      rr_ptr_r       <= rr_next_s;
    end else if (xif.result_ready) begin
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= result_valid_r;
    end
  end

  // One-cycle error pulse when a result arrives with no credit outstanding
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (grant_valid_s && (cnt_r[grant_idx_s] == '0)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= 1'b0;
    end
  end

  assign xif.result_valid = result_valid_r;
  assign xif.result_id    = result_id_r;
  assign xif.result_data  = result_data_r;
  assign xif.result_rd    = result_rd_r;
  assign xif.result_we    = result_we_r;
  assign err_o            = err_r;

`ifdef XIF_DISP_PERF_EN
  logic [31:0] perf_issue_r;
  logic [31:0] perf_stall_r;

  // Free-running wrap-around counts of accepted issues and credit-stall cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issue_r <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (issue_hs_s) begin
        perf_issue_r <= perf_issue_r + 32'd1;
      end else begin
        perf_issue_r <= perf_issue_r;
      end
      if (xif.issue_valid && stall_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign perf_issue_cnt_o = perf_issue_r;
  assign perf_stall_cnt_o = perf_stall_r;
`else
  assign perf_issue_cnt_o = 32'd0;
  assign perf_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_xif_credit_dispatcher.sv
// Self-checking bench for xif_credit_dispatcher: directed scenarios plus a
// randomized mixed run, all checked against a transaction-level model.
module tb_xif_credit_dispatcher;
  localparam int N = 4, NR = 3, NS = 4, DEF = 0, MAXO = 4, IDW = 4, XL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] sign_tab [NR][NS];
  logic       en_tab   [NR][NS];
  logic [NR*NS*10-1:0] rules_sign;
  logic [NR*NS-1:0]    rules_en;

  logic [N-1:0]     cp_iv, cp_ir, cp_acc, cp_wb, cp_rv, cp_rr, cp_rwe;
  logic [31:0]      cp_instr;
  logic [IDW-1:0]   cp_id;
  logic [N*IDW-1:0] cp_rid;
  logic [N*XL-1:0]  cp_rdata;
  logic [N*5-1:0]   cp_rrd;
  logic             err;
  logic [31:0]      perf_i, perf_s;

  xif_credit_dispatcher_if #(.ID_W(IDW), .XLEN(XL)) xif ();

  xif_credit_dispatcher #(
    .N_COPROC(N), .N_RULES(NR), .N_SIGN(NS), .DEFAULT_IDX(DEF),
    .MAX_OUTST(MAXO), .ID_W(IDW), .XLEN(XL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rules_sign_i(rules_sign), .rules_en_i(rules_en),
    .xif(xif.slave), .cp_issue_valid_o(cp_iv), .cp_issue_ready_i(cp_ir),
    .cp_issue_instr_o(cp_instr), .cp_issue_id_o(cp_id), .cp_accept_i(cp_acc),
    .cp_writeback_i(cp_wb), .cp_result_valid_i(cp_rv), .cp_result_ready_o(cp_rr),
    .cp_result_id_i(cp_rid), .cp_result_data_i(cp_rdata), .cp_result_rd_i(cp_rrd),
    .cp_result_we_i(cp_rwe), .err_o(err), .perf_issue_cnt_o(perf_i), .perf_stall_cnt_o(perf_s)
  );

  always_comb begin
    rules_sign = '0;
    rules_en   = '0;
    for (int r = 0; r < NR; r++) begin
      for (int s = 0; s < NS; s++) begin
        rules_sign[(r*NS+s)*10 +: 10] = sign_tab[r][s];
        rules_en[r*NS+s]              = en_tab[r][s];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state
  int             mcnt [N];
  int             mrr;
  logic           mvalid, mwe, merr;
  logic [IDW-1:0] mid;
  logic [XL-1:0]  mdata;
  logic [4:0]     mrd;
  logic [31:0]    mperf_issue, mperf_stall;
  // Model expectations for the current cycle
  int             esel, eg;
  logic           estall, eready, eacc, ewb, egv;
  logic [N-1:0]   eiv, ecrr;

  function automatic logic [31:0] exp_pi();
`ifdef XIF_DISP_PERF_EN
    return mperf_issue;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_ps();
`ifdef XIF_DISP_PERF_EN
    return mperf_stall;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) mcnt[c] = 0;
    mrr = 0; mvalid = 1'b0; mwe = 1'b0; merr = 1'b0;
    mid = '0; mdata = '0; mrd = '0;
    mperf_issue = 32'd0; mperf_stall = 32'd0;
  endtask

  task automatic model_comb();
    logic [9:0] sg;
    bit found;
    sg = {xif.issue_instr[6:0], xif.issue_instr[14:12]};
    esel = DEF; found = 1'b0;
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < NS; s++)
        if (!found && en_tab[r][s] && sign_tab[r][s] == sg) begin esel = r; found = 1'b1; end
    estall = (mcnt[esel] == MAXO);
    eiv = '0;
    if (xif.issue_valid && !estall) eiv[esel] = 1'b1;
    eready = cp_ir[esel] && !estall;
    eacc   = cp_acc[esel] && !estall;
    ewb    = cp_wb[esel] && !estall;
    egv = 1'b0; eg = 0;
    if (!mvalid || xif.result_ready)
      for (int k = 0; k < N; k++)
        if (!egv && cp_rv[(mrr+k)%N]) begin egv = 1'b1; eg = (mrr+k)%N; end
    ecrr = '0;
    if (egv) ecrr[eg] = 1'b1;
  endtask

  // Advance the model by one clock and the simulation to 1 ns after the edge
  task automatic tick();
    bit inc, dec;
    model_comb();
    if (xif.issue_valid && eready) mperf_issue = mperf_issue + 32'd1;
    if (xif.issue_valid && estall) mperf_stall = mperf_stall + 32'd1;
    merr = egv && (mcnt[eg] == 0);
    for (int c = 0; c < N; c++) begin
      inc = (c == esel) && xif.issue_valid && eready && eacc && ewb;
      dec = egv && (eg == c);
      if (inc && !dec) mcnt[c]++;
      else if (dec && !inc && mcnt[c] > 0) mcnt[c]--;
    end
    if (egv) begin
      mvalid = 1'b1;
      mid = cp_rid[eg*IDW +: IDW]; mdata = cp_rdata[eg*XL +: XL];
      mrd = cp_rrd[eg*5 +: 5]; mwe = cp_rwe[eg];
      mrr = (eg + 1) % N;
    end else if (xif.result_ready) begin
      mvalid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_payload();
    for (int c = 0; c < N; c++) begin
      cp_rid[c*IDW +: IDW] = IDW'($urandom);
      cp_rdata[c*XL +: XL] = $urandom;
      cp_rrd[c*5 +: 5]     = 5'($urandom);
      cp_rwe[c]            = 1'($urandom);
    end
  endtask

  task automatic idle_inputs();
    xif.issue_valid = 1'b0; xif.issue_instr = 32'd0; xif.issue_id = '0;
    xif.result_ready = 1'b1;
    cp_ir = '0; cp_acc = '0; cp_wb = '0; cp_rv = '0;
    rand_payload();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (xif.result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=0", xif.result_valid); end
    n_cmp++; if (xif.result_data !== 32'd0 || xif.result_id !== 4'd0 || xif.result_rd !== 5'd0 || xif.result_we !== 1'b0) begin n_bad++; $display("FAIL reset_payload got=%h/%h/%h/%b exp=0", xif.result_data, xif.result_id, xif.result_rd, xif.result_we); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (perf_i !== 32'd0 || perf_s !== 32'd0) begin n_bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_i, perf_s); end
    n_cmp++; if (cp_iv !== 4'b0000 || cp_rr !== 4'b0000) begin n_bad++; $display("FAIL reset_cp got=%b/%b exp=0000/0000", cp_iv, cp_rr); end
  endtask

  task automatic test_routing();
    do_reset();
    cp_ir = 4'b1111; cp_acc = 4'b1111; cp_wb = 4'b1111;
    xif.issue_valid = 1'b1; xif.issue_instr = 32'h0000_102B; xif.issue_id = 4'h5;
    #1; model_comb();
    n_cmp++; if (cp_iv !== 4'b0010) begin n_bad++; $display("FAIL route_rule1 got=%b exp=0010", cp_iv); end
    n_cmp++; if (xif.issue_ready !== 1'b1 || xif.issue_accept !== 1'b1 || xif.issue_writeback !== 1'b1) begin n_bad++; $display("FAIL route_hs got=%b%b%b exp=111", xif.issue_ready, xif.issue_accept, xif.issue_writeback); end
    n_cmp++; if (cp_instr !== 32'h0000_102B || cp_id !== 4'h5) begin n_bad++; $display("FAIL route_bcast got=%h/%h exp=0000102b/5", cp_instr, cp_id); end
    tick();
    xif.issue_instr = 32'h0000_0033; #1;
    n_cmp++; if (cp_iv !== 4'b0001) begin n_bad++; $display("FAIL route_default got=%b exp=0001", cp_iv); end
    tick();
    for (int r = 0; r < NR; r++) for (int s = 0; s < NS; s++) en_tab[r][s] = 1'b0;
    xif.issue_instr = 32'h0000_102B; #1;
    n_cmp++; if (cp_iv !== 4'b0001) begin n_bad++; $display("FAIL route_disabled got=%b exp=0001", cp_iv); end
    tick();
    for (int r = 0; r < NR; r++) for (int s = 0; s < NS; s++) en_tab[r][s] = 1'b1;
    xif.issue_valid = 1'b0; #1;
  endtask

  task automatic test_credit_stall();
    do_reset();
    cp_ir = 4'b1111; cp_acc = 4'b1111; cp_wb = 4'b1111;
    xif.issue_valid = 1'b1; xif.issue_instr = 32'h0000_005B;
    for (int i = 0; i < MAXO; i++) begin
      #1;
      n_cmp++; if (xif.issue_ready !== 1'b1 || cp_iv !== 4'b0100) begin n_bad++; $display("FAIL credit_fill%0d got=%b/%b exp=1/0100", i, xif.issue_ready, cp_iv); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (xif.issue_ready !== 1'b0 || cp_iv !== 4'b0000 || xif.issue_accept !== 1'b0) begin n_bad++; $display("FAIL credit_stall%0d got=%b/%b/%b exp=0/0000/0", i, xif.issue_ready, cp_iv, xif.issue_accept); end
      tick();
    end
    n_cmp++; if (perf_s !== exp_ps() || perf_i !== exp_pi()) begin n_bad++; $display("FAIL credit_perf got=%0d/%0d exp=%0d/%0d", perf_s, perf_i, exp_ps(), exp_pi()); end
    cp_rv = 4'b0100; #1;
    n_cmp++; if (cp_rr !== 4'b0100 || xif.issue_ready !== 1'b0) begin n_bad++; $display("FAIL credit_grant_cycle got=%b/%b exp=0100/0", cp_rr, xif.issue_ready); end
    tick();
    cp_rv = 4'b0000; #1;
    n_cmp++; if (xif.issue_ready !== 1'b1 || xif.result_valid !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL credit_resume got=%b/%b/%b exp=1/1/0", xif.issue_ready, xif.result_valid, err); end
    tick();
    xif.issue_valid = 1'b0; tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    cp_rv = 4'b1111; xif.result_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_payload(); #1; model_comb();
      n_cmp++; if (cp_rr !== 4'(1 << (i % N))) begin n_bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, cp_rr, 4'(1 << (i % N))); end
      tick();
      n_cmp++; if (xif.result_valid !== 1'b1 || xif.result_data !== mdata || xif.result_id !== mid || err !== merr) begin n_bad++; $display("FAIL rr_out%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", i, xif.result_valid, xif.result_data, xif.result_id, err, mdata, mid, merr); end
    end
  endtask

  task automatic test_backpressure_err();
    logic [XL-1:0] held;
    held = mdata;
    cp_rv = 4'b1000; xif.result_ready = 1'b0; rand_payload();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (cp_rr !== 4'b0000 || xif.result_valid !== 1'b1 || xif.result_data !== held) begin n_bad++; $display("FAIL bp_hold%0d got=%b/%b/%h exp=0000/1/%h", i, cp_rr, xif.result_valid, xif.result_data, held); end
      tick();
    end
    xif.result_ready = 1'b1; #1;
    n_cmp++; if (cp_rr !== 4'b1000) begin n_bad++; $display("FAIL bp_release got=%b exp=1000", cp_rr); end
    tick();
    cp_rv = 4'b0000;
    n_cmp++; if (err !== 1'b1 || xif.result_data !== mdata) begin n_bad++; $display("FAIL bp_err_pulse got=%b/%h exp=1/%h", err, xif.result_data, mdata); end
    tick();
    n_cmp++; if (err !== 1'b0 || xif.result_valid !== 1'b0) begin n_bad++; $display("FAIL bp_err_end got=%b/%b exp=0/0", err, xif.result_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cp_ir = 4'b1111; cp_acc = 4'b1111; cp_wb = 4'b1111;
    xif.issue_valid = 1'b1; xif.issue_instr = 32'h0000_102B;
    tick(); tick();
    xif.issue_valid = 1'b0; cp_rv = 4'b0001; tick();
    cp_rv = 4'b0000; xif.result_ready = 1'b0; #1;
    n_cmp++; if (xif.result_valid !== 1'b1 || mcnt[1] != 2) begin n_bad++; $display("FAIL midrst_pre got=%b exp=1", xif.result_valid); end
    rst_n = 1'b0; #1;
    n_cmp++; if (xif.result_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_async got=%b exp=0", xif.result_valid); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; xif.result_ready = 1'b1; cp_rv = 4'b1111; #1; model_comb();
    n_cmp++; if (cp_rr !== 4'b0001) begin n_bad++; $display("FAIL midrst_rrptr got=%b exp=0001", cp_rr); end
    tick();
    cp_rv = 4'b0010; #1;
    n_cmp++; if (cp_rr !== 4'b0010) begin n_bad++; $display("FAIL midrst_grant1 got=%b exp=0010", cp_rr); end
    tick();
    cp_rv = 4'b0000;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL midrst_cnt1_cleared got=%b exp=1", err); end
    tick();
  endtask

  task automatic test_random_mixed();
    int r, s;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0)
        for (int a = 0; a < NR; a++) for (int b = 0; b < NS; b++) en_tab[a][b] = ($urandom_range(0, 4) != 0);
      xif.issue_valid = ($urandom_range(0, 9) < 7);
      xif.issue_id = IDW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        xif.issue_instr = $urandom;
      end else begin
        r = $urandom_range(0, NR-1); s = $urandom_range(0, NS-1);
        xif.issue_instr = $urandom;
        xif.issue_instr[6:0] = sign_tab[r][s][9:3];
        xif.issue_instr[14:12] = sign_tab[r][s][2:0];
      end
      for (int c = 0; c < N; c++) begin
        cp_ir[c]  = ($urandom_range(0, 9) < 8);
        cp_acc[c] = ($urandom_range(0, 9) < 8);
        cp_wb[c]  = ($urandom_range(0, 9) < 8);
        cp_rv[c]  = (mcnt[c] > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 3);
      end
      xif.result_ready = ($urandom_range(0, 9) < 7);
      rand_payload();
      #1; model_comb();
      n_cmp++; if (cp_iv !== eiv || xif.issue_ready !== eready) begin n_bad++; $display("FAIL mix_issue c%0d got=%b/%b exp=%b/%b", i, cp_iv, xif.issue_ready, eiv, eready); end
      n_cmp++; if (xif.issue_accept !== eacc || xif.issue_writeback !== ewb) begin n_bad++; $display("FAIL mix_accwb c%0d got=%b/%b exp=%b/%b", i, xif.issue_accept, xif.issue_writeback, eacc, ewb); end
      n_cmp++; if (cp_rr !== ecrr) begin n_bad++; $display("FAIL mix_grant c%0d got=%b exp=%b", i, cp_rr, ecrr); end
      tick();
      n_cmp++; if (xif.result_valid !== mvalid || err !== merr) begin n_bad++; $display("FAIL mix_out c%0d got=%b/%b exp=%b/%b", i, xif.result_valid, err, mvalid, merr); end
      if (mvalid) begin
        n_cmp++; if (xif.result_id !== mid || xif.result_data !== mdata || xif.result_rd !== mrd || xif.result_we !== mwe) begin n_bad++; $display("FAIL mix_payload c%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", i, xif.result_id, xif.result_data, xif.result_rd, xif.result_we, mid, mdata, mrd, mwe); end
      end
    end
    n_cmp++; if (perf_i !== exp_pi() || perf_s !== exp_ps()) begin n_bad++; $display("FAIL mix_perf got=%0d/%0d exp=%0d/%0d", perf_i, perf_s, exp_pi(), exp_ps()); end
  endtask

  initial begin
    logic [6:0] opc [NR];
    opc[0] = 7'h0B; opc[1] = 7'h2B; opc[2] = 7'h5B;
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < NS; s++) begin
        sign_tab[r][s] = {opc[r], 3'(s)};
        en_tab[r][s]   = 1'b1;
      end
    sign_tab[2][3] = {7'h2B, 3'd1};
    test_reset();
    test_routing();
    test_credit_stall();
    test_round_robin();
    test_backpressure_err();
    test_reset_mid();
    test_random_mixed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
